// File: rtl/adc0804_responder_pkg.sv
// Shared types and constants for the ADC0804 responder.
package adc0804_responder_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [DATA_W-1:0] RESET_DATA = 8'h00;

    // Converter handshake states
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONVERT,
        DONE
    } state_t;

endpackage

// File: rtl/adc_pin_sync.sv
// Synchronizer for one asynchronous pin plus single-cycle edge pulses.
//   i_clk_100MHz  system clock
//   i_reset       synchronous, active-high reset
//   i_pin         asynchronous pin input
//   o_level       synchronized pin level (registered)
//   o_rise_c      combinational 1-cycle pulse on a synchronized rising edge
//   o_fall_c      combinational 1-cycle pulse on a synchronized falling edge
// RESET_VAL is the idle level of the pin, so leaving reset produces no
// spurious edge when the pin sits at its idle level.
module adc_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic i_clk_100MHz,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain followed by the edge-detect history flop
    always_ff @(posedge i_clk_100MHz) begin
        if (i_reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level  = sync_q[SYNC_STAGES-1];
    assign o_rise_c =  o_level & ~prev_q;
    assign o_fall_c = ~o_level &  prev_q;

endmodule

// File: rtl/adc0804_responder.sv
// ADC0804 emulator: converter side of the CS_n/WR_n/RD_n/INTR_n handshake.
// A WR_n rising edge with CS_n low starts a conversion that lasts CONV_CLKS
// rising edges of i_adc_clk; INTR_n then goes low until the result is read.
//   i_clk_100MHz  system clock
//   i_reset       synchronous, active-high reset
//   i_adc_clk     conversion clock, asynchronous
//   i_cs_n        chip select, active low, asynchronous
//   i_wr_n        start strobe, active low, asynchronous
//   i_rd_n        read strobe, active low, asynchronous
//   i_sample      value captured at conversion start
//   o_intr_n      end-of-conversion flag, active low
//   o_adc_data    conversion result
//   o_data_oe     1 = top level drives o_adc_data onto the bus
//   o_busy        1 while a conversion is in progress
// Build option: define ADC_RESPONDER_RAMP_EN to replace i_sample with an
// internal ramp that advances on every completed conversion.
module adc0804_responder
    import adc0804_responder_pkg::*;
#(
    parameter int unsigned CONV_CLKS   = 66,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk_100MHz,
    input  logic              i_reset,
    input  logic              i_adc_clk,
    input  logic              i_cs_n,
    input  logic              i_wr_n,
    input  logic              i_rd_n,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_intr_n,
    output logic [DATA_W-1:0] o_adc_data,
    output logic              o_data_oe,
    output logic              o_busy
);

    logic adc_rise, cs_s, cs_rise, wr_s, wr_rise, wr_fall, rd_s, rd_fall;
    logic unused_adc_level, unused_adc_fall, unused_cs_fall, unused_rd_rise;

    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_adc (
        .i_clk_100MHz (i_clk_100MHz),
        .i_reset      (i_reset),
        .i_pin        (i_adc_clk),
        .o_level      (unused_adc_level),
        .o_rise_c     (adc_rise),
        .o_fall_c     (unused_adc_fall)
    );

    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk_100MHz (i_clk_100MHz),
        .i_reset      (i_reset),
        .i_pin        (i_cs_n),
        .o_level      (cs_s),
        .o_rise_c     (cs_rise),
        .o_fall_c     (unused_cs_fall)
    );

    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
        .i_clk_100MHz (i_clk_100MHz),
        .i_reset      (i_reset),
        .i_pin        (i_wr_n),
        .o_level      (wr_s),
        .o_rise_c     (wr_rise),
        .o_fall_c     (wr_fall)
    );

    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rd (
        .i_clk_100MHz (i_clk_100MHz),
        .i_reset      (i_reset),
        .i_pin        (i_rd_n),
        .o_level      (rd_s),
        .o_rise_c     (unused_rd_rise),
        .o_fall_c     (rd_fall)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   pend_q, pend_d;
    logic                intr_n_q, intr_n_d;
    logic                data_oe_q;
    logic                busy_q;
    logic                done_c;
    logic [DATA_W-1:0]   capture_c;

`ifdef ADC_RESPONDER_RAMP_EN
    logic [DATA_W-1:0] ramp_q;
    logic              unused_sample;

    assign unused_sample = ^i_sample;
    assign capture_c     = ramp_q;

    // Ramp advances only on completed conversions; aborts leave it alone
    always_ff @(posedge i_clk_100MHz) begin
        if (i_reset) begin
            ramp_q <= RESET_DATA;
        end else if (done_c) begin
            ramp_q <= ramp_q + DATA_W'(1);
        end
    end
`else
    assign capture_c = i_sample;
`endif

    // State and datapath registers
    always_ff @(posedge i_clk_100MHz) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= RESET_DATA;
            pend_q    <= RESET_DATA;
            intr_n_q  <= 1'b1;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            pend_q    <= pend_d;
            intr_n_q  <= intr_n_d;
            data_oe_q <= ~cs_s & ~rd_s;
            busy_q    <= (state_d == CONVERT);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        pend_d   = pend_q;
        intr_n_d = intr_n_q;
        done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_s && !wr_s) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (wr_rise && !cs_s) begin
                    state_d = CONVERT;
                    pend_d  = capture_c;
                    cnt_d   = '0;
                end else if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            CONVERT: begin
                if (wr_fall && !cs_s) begin
                    // Restart: drop this conversion, keep the old result
                    state_d = ARMED;
                end else if (adc_rise) begin
                    if (cnt_q < CNT_W'(CONV_CLKS)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_W'(CONV_CLKS - 1)) begin
                        result_d = pend_q;
                        intr_n_d = 1'b0;
                        state_d  = DONE;
                        done_c   = 1'b1;
                    end
                end
            end

            DONE: begin
                if (!cs_s && rd_fall) begin
                    intr_n_d = 1'b1;
                    state_d  = IDLE;
                end else if (!cs_s && wr_fall) begin
                    intr_n_d = 1'b1;
                    state_d  = ARMED;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_intr_n   = intr_n_q;
    assign o_adc_data = result_q;
    assign o_data_oe  = data_oe_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_adc0804_responder.sv
// Self-checking bench for adc0804_responder: a table of pin-level vectors
// for chip-select gating, then hand-written conversion sequences.
module tb_adc0804_responder;

    localparam int unsigned CONV = 66;
    localparam int unsigned SYNC = 2;

    logic       i_clk_100MHz;
    logic       i_reset;
    logic       i_adc_clk;
    logic       i_cs_n;
    logic       i_wr_n;
    logic       i_rd_n;
    logic [7:0] i_sample;
    logic       o_intr_n;
    logic [7:0] o_adc_data;
    logic       o_data_oe;
    logic       o_busy;

    adc0804_responder #(.CONV_CLKS(CONV), .SYNC_STAGES(SYNC)) dut (
        .i_clk_100MHz (i_clk_100MHz),
        .i_reset      (i_reset),
        .i_adc_clk    (i_adc_clk),
        .i_cs_n       (i_cs_n),
        .i_wr_n       (i_wr_n),
        .i_rd_n       (i_rd_n),
        .i_sample     (i_sample),
        .o_intr_n     (o_intr_n),
        .o_adc_data   (o_adc_data),
        .o_data_oe    (o_data_oe),
        .o_busy       (o_busy)
    );

    initial i_clk_100MHz = 1'b0;
    always #5 i_clk_100MHz = ~i_clk_100MHz;

    // Fast conversion clock, offset so its edges never coincide with stimulus
    initial begin
        i_adc_clk = 1'b0;
        #3;
        forever begin
            i_adc_clk = 1'b1;
            #20;
            i_adc_clk = 1'b0;
            #20;
        end
    end

    int adc_rises = 0;
    always @(posedge i_adc_clk) adc_rises = adc_rises + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int snap     = 0;

    logic [7:0] m_result;
    logic [7:0] m_pend;
`ifdef ADC_RESPONDER_RAMP_EN
    logic [7:0] m_ramp;
`endif

    typedef struct {
        logic cs_n;
        logic wr_n;
        logic rd_n;
        logic exp_oe;
        logic exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk_100MHz);
    endtask

    // WR pulse of 100 ns; snapshot the adc edge count once the release is sampled
    task automatic start_conv(input logic [7:0] s);
        i_sample = s;
        i_wr_n   = 1'b0;
        tick(10);
        i_wr_n   = 1'b1;
        @(posedge i_clk_100MHz);
        snap = adc_rises;
`ifdef ADC_RESPONDER_RAMP_EN
        m_pend = m_ramp;
`else
        m_pend = s;
`endif
        @(negedge i_clk_100MHz);
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        while ((adc_rises - snap) < n && k < 1000) begin
            @(negedge i_clk_100MHz);
            k++;
        end
    endtask

    task automatic wait_intr(input string name);
        int k = 0;
        while (o_intr_n !== 1'b0 && k < 1000) begin
            @(negedge i_clk_100MHz);
            k++;
        end
        check({name, " intr_fall"}, 32'(o_intr_n), 32'd0);
        check({name, " adc_edges"}, 32'(adc_rises - snap), 32'(CONV));
        check({name, " busy_done"}, 32'(o_busy), 32'd0);
        m_result = m_pend;
`ifdef ADC_RESPONDER_RAMP_EN
        m_ramp = m_ramp + 8'd1;
`endif
    endtask

    task automatic do_read(input string name);
        i_rd_n = 1'b0;
        tick(SYNC + 2);
        check({name, " rd_oe"},   32'(o_data_oe),  32'd1);
        check({name, " rd_data"}, 32'(o_adc_data), 32'(m_result));
        check({name, " rd_intr"}, 32'(o_intr_n),   32'd1);
        i_rd_n = 1'b1;
        tick(SYNC + 2);
        check({name, " rd_oe_off"}, 32'(o_data_oe), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            cs wr rd  oe busy
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // RD with CS high
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // WR low with CS high
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // WR rise with CS high
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // read in IDLE
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // ARMED
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // CS rises first
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // no conversion
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        m_result = 8'h00;
        m_pend   = 8'h00;
`ifdef ADC_RESPONDER_RAMP_EN
        m_ramp   = 8'h00;
`endif
        i_reset  = 1'b1;
        i_cs_n   = 1'b1;
        i_wr_n   = 1'b1;
        i_rd_n   = 1'b1;
        i_sample = 8'h00;
        tick(3);
        i_reset  = 1'b0;
        tick(1);
        check("reset intr_n", 32'(o_intr_n),   32'd1);
        check("reset data",   32'(o_adc_data), 32'h00);
        check("reset oe",     32'(o_data_oe),  32'd0);
        check("reset busy",   32'(o_busy),     32'd0);

        for (int i = 0; i < 10; i++) begin
            i_cs_n = vecs[i].cs_n;
            i_wr_n = vecs[i].wr_n;
            i_rd_n = vecs[i].rd_n;
            tick(SYNC + 4);
            check($sformatf("vec%0d oe", i),   32'(o_data_oe),  32'(vecs[i].exp_oe));
            check($sformatf("vec%0d busy", i), 32'(o_busy),     32'(vecs[i].exp_busy));
            check($sformatf("vec%0d intr", i), 32'(o_intr_n),   32'd1);
            check($sformatf("vec%0d data", i), 32'(o_adc_data), 32'h00);
        end

        // Basic conversion
        i_cs_n = 1'b0;
        tick(4);
        start_conv(8'hA5);
        tick(3);
        check("basic busy", 32'(o_busy),   32'd1);
        check("basic intr", 32'(o_intr_n), 32'd1);
        wait_intr("basic");
        do_read("basic");

        // Restart abort: second WR after 30 adc edges
        start_conv(8'h77);
        wait_rises(30);
        check("restart busy_mid", 32'(o_busy),   32'd1);
        check("restart intr_mid", 32'(o_intr_n), 32'd1);
        start_conv(8'h3C);
        check("restart intr_after_wr", 32'(o_intr_n), 32'd1);
        wait_intr("restart");
        do_read("restart");

        // Early read returns the previous result
        start_conv(8'h11);
        wait_intr("prev");
        do_read("prev");
        start_conv(8'h22);
        wait_rises(10);
        i_rd_n = 1'b0;
        tick(SYNC + 2);
        check("early oe",   32'(o_data_oe),  32'd1);
        check("early data", 32'(o_adc_data), 32'(m_result));
        check("early intr", 32'(o_intr_n),   32'd1);
        check("early busy", 32'(o_busy),     32'd1);
        i_rd_n = 1'b1;
        wait_intr("early");
        do_read("early");

        // Reset in the middle of a conversion
        start_conv(8'h5A);
        wait_rises(40);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("rst_mid intr", 32'(o_intr_n),   32'd1);
        check("rst_mid busy", 32'(o_busy),     32'd0);
        check("rst_mid data", 32'(o_adc_data), 32'h00);
        m_result = 8'h00;
`ifdef ADC_RESPONDER_RAMP_EN
        m_ramp   = 8'h00;
`endif
        tick(SYNC + 4);
        check("rst_mid busy_later", 32'(o_busy), 32'd0);
        do_read("rst_mid");

`ifdef ADC_RESPONDER_RAMP_EN
        // Ramp: 257 back-to-back conversions read 00..FF then 00
        for (int i = 0; i < 257; i++) begin
            start_conv(8'hEE);
            wait_intr($sformatf("ramp%0d", i));
            check($sformatf("ramp%0d value", i), 32'(o_adc_data), 32'(i % 256));
            do_read($sformatf("ramp%0d", i));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
